// File: rtl/i2c_cmd_sequencer_pkg.sv
// Shared types and constants for the I2C command sequencer: FSM encoding,
// controller i_ctrl bit positions and the queued command layout.
package i2c_cmd_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LOAD       = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_WAIT_RDY   = 3'd3,
      ST_WAIT_DONE  = 3'd4
   } state_t;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_RW       = 1;
   localparam int CTRL_MODE_LSB = 2;
   localparam int CTRL_MODE_MSB = 3;

   localparam logic [1:0] OP_MODE_CPU_1B = 2'b00;

   typedef struct packed {
      logic       rw;
      logic [7:0] reg_addr;
      logic [7:0] wdata;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous show-ahead FIFO holding queued commands; head entry is always
// visible on o_data while the FIFO is non-empty.
module i2c_cmd_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 17
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      level_q;
   logic             push_ok, pop_ok;

   assign o_full  = (level_q == (AW+1)'(DEPTH));
   assign o_empty = (level_q == '0);
   assign push_ok = i_push && !o_full;
   assign pop_ok  = i_pop && !o_empty;

   // NOTE: storage has no reset; only pointers and level define what is valid.
   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   assign o_data  = mem_q[rd_ptr_q];
   assign o_level = level_q;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues single-register I2C read/write commands and issues them one at a
// time to i2c_controller, tracking completion from its synchronised ready bit.
module i2c_cmd_sequencer
   import i2c_cmd_sequencer_pkg::*;
#(
   parameter int         DEPTH    = 8,
   parameter logic [6:0] DEV_ADDR = 7'h68,
   parameter int         TIMEOUT  = 65535
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_cmd_valid,
   output logic                   o_cmd_ready,
   input  logic                   i_cmd_rw,
   input  logic [7:0]             i_cmd_reg,
   input  logic [7:0]             i_cmd_wdata,
   output logic [6:0]             o_dev_addr,
   output logic [7:0]             o_reg_addr,
   output logic [7:0]             o_w_data,
   output logic [31:0]            o_ctrl,
   input  logic [31:0]            i_status,
   input  logic [7:0]             i_rd_data,
   output logic                   o_rd_valid,
   output logic [7:0]             o_rd_data,
   output logic [7:0]             o_rd_reg,
   output logic                   o_busy,
   output logic                   o_err_timeout,
   input  logic                   i_clr_err,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   cmd_t        cmd_q, cmd_d, fifo_head;
   logic [7:0]  reg_addr_q, reg_addr_d, w_data_q, w_data_d;
   logic [7:0]  rd_data_q, rd_data_d, rd_reg_q, rd_reg_d;
   logic        ctrl_en_q, ctrl_en_d, ctrl_rw_q, ctrl_rw_d;
   logic [1:0]  starts_q, starts_d, need;
   logic [15:0] timer_q, timer_d;
   logic        rd_valid_q, rd_valid_d, err_q, err_d, err_set;
   logic        rdy_meta_q, rdy_s_q, rdy_prev_q, rdy_fall, tmo_hit;
   logic        fifo_pop, fifo_full, fifo_empty;
   logic        unused_status;

   assign unused_status = ^i_status[31:1];

   i2c_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_cmd_valid),
      .i_data  ({i_cmd_rw, i_cmd_reg, i_cmd_wdata}),
      .i_pop   (fifo_pop),
      .o_data  (fifo_head),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_level (o_level)
   );

   assign rdy_fall = rdy_prev_q && !rdy_s_q;
   assign tmo_hit  = (timer_q == TMO_LAST);
   assign need     = cmd_q.rw ? 2'd2 : 2'd1;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      reg_addr_d = reg_addr_q;
      w_data_d   = w_data_q;
      ctrl_en_d  = ctrl_en_q;
      ctrl_rw_d  = ctrl_rw_q;
      starts_d   = starts_q;
      rd_data_d  = rd_data_q;
      rd_reg_d   = rd_reg_q;
      rd_valid_d = 1'b0;
      fifo_pop   = 1'b0;
      err_set    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && rdy_s_q) begin
               fifo_pop = 1'b1;
               cmd_d    = fifo_head;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            reg_addr_d = cmd_q.reg_addr;
            w_data_d   = cmd_q.wdata;
            ctrl_rw_d  = cmd_q.rw;
            ctrl_en_d  = 1'b1;
            starts_d   = 2'd0;
            state_d    = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (rdy_fall) begin
               starts_d = starts_q + 2'd1;
               // Dropping enable at the final start keeps the controller from re-triggering.
               if (starts_q + 2'd1 == need) begin
                  ctrl_en_d = 1'b0;
                  state_d   = ST_WAIT_DONE;
               end else begin
                  state_d   = ST_WAIT_RDY;
               end
            end else if (tmo_hit) begin
               ctrl_en_d = 1'b0;
               err_set   = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_WAIT_RDY: begin
            if (rdy_s_q) begin
               state_d = ST_WAIT_START;
            end else if (tmo_hit) begin
               ctrl_en_d = 1'b0;
               err_set   = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_WAIT_DONE: begin
            if (rdy_s_q) begin
               if (cmd_q.rw) begin
                  rd_data_d  = i_rd_data;
                  rd_reg_d   = cmd_q.reg_addr;
                  rd_valid_d = 1'b1;
               end
               state_d = ST_IDLE;
            end else if (tmo_hit) begin
               ctrl_en_d = 1'b0;
               err_set   = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            ctrl_en_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase

      err_d   = err_set ? 1'b1 : (i_clr_err ? 1'b0 : err_q);
      timer_d = (state_d != state_q) ? 16'd0 : timer_q + 16'd1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         cmd_q      <= '0;
         reg_addr_q <= '0;
         w_data_q   <= '0;
         ctrl_en_q  <= 1'b0;
         ctrl_rw_q  <= 1'b0;
         starts_q   <= '0;
         timer_q    <= '0;
         rd_data_q  <= '0;
         rd_reg_q   <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
         rdy_meta_q <= 1'b0;
         rdy_s_q    <= 1'b0;
         rdy_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         reg_addr_q <= reg_addr_d;
         w_data_q   <= w_data_d;
         ctrl_en_q  <= ctrl_en_d;
         ctrl_rw_q  <= ctrl_rw_d;
         starts_q   <= starts_d;
         timer_q    <= timer_d;
         rd_data_q  <= rd_data_d;
         rd_reg_q   <= rd_reg_d;
         rd_valid_q <= rd_valid_d;
         err_q      <= err_d;
         rdy_meta_q <= i_status[0];
         rdy_s_q    <= rdy_meta_q;
         rdy_prev_q <= rdy_s_q;
      end
   end

   always_comb begin
      o_ctrl                              = '0;
      o_ctrl[CTRL_EN]                     = ctrl_en_q;
      o_ctrl[CTRL_RW]                     = ctrl_rw_q;
      o_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] = OP_MODE_CPU_1B;
   end

   assign o_cmd_ready   = !fifo_full;
   assign o_dev_addr    = DEV_ADDR;
   assign o_reg_addr    = reg_addr_q;
   assign o_w_data      = w_data_q;
   assign o_rd_valid    = rd_valid_q;
   assign o_rd_data     = rd_data_q;
   assign o_rd_reg      = rd_reg_q;
   assign o_err_timeout = err_q;
   assign o_busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule
